// File: rtl/irq_pkg.sv
// Shared constants, width helpers and the fixed-priority encoder used by
// the multi-source interrupt controller.
package irq_pkg;

    localparam int MAX_SRC = 32;

    typedef int unsigned        width_t;
    typedef logic [MAX_SRC-1:0] src_vec_t;

    function automatic width_t id_w(input int n);
        return (n > 1) ? width_t'($clog2(n)) : width_t'(1);
    endfunction

    function automatic width_t pulse_cnt_w(input int len);
        return width_t'($clog2(len + 1));
    endfunction

    // Index 0 is the highest priority; an empty request vector yields 0.
    function automatic int lowest_set(input src_vec_t req);
        int idx;
        idx = 0;
        for (int i = MAX_SRC - 1; i >= 0; i--) begin
            if (req[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/irq_ctrl_if.sv
// Request/acknowledge/status bundle between interrupt sources, the CPU
// side and the interrupt controller.
interface irq_ctrl_if #(
    parameter int NUM_SRC = 4
);
    import irq_pkg::*;

    localparam int ID_W = id_w(NUM_SRC);

    logic [NUM_SRC-1:0] src;
    logic [NUM_SRC-1:0] mask;
    logic               ack_valid;
    logic [ID_W-1:0]    ack_id;
    logic [NUM_SRC-1:0] pending;
    logic [NUM_SRC-1:0] overflow;
    logic               irq;
    logic               irq_pulse;
    logic [ID_W-1:0]    irq_id;
    logic               irq_valid;

    modport master (
        output src, mask, ack_valid, ack_id,
        input  pending, overflow, irq, irq_pulse, irq_id, irq_valid
    );

    modport slave (
        input  src, mask, ack_valid, ack_id,
        output pending, overflow, irq, irq_pulse, irq_id, irq_valid
    );

endinterface

// File: rtl/irq_sync_edge.sv
// Multi-flop synchroniser for one asynchronous request line followed by a
// rising-edge detector on the synchronised value.
module irq_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic edge_out
);

    logic [SYNC_STAGES-1:0] sync_d, sync_q;
    logic                   prev_d, prev_q;

    always_comb begin
        sync_d = {sync_q[SYNC_STAGES-2:0], async_in};
        prev_d = sync_q[SYNC_STAGES-1];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    assign edge_out = sync_q[SYNC_STAGES-1] & ~prev_q;

endmodule

// File: rtl/irq_ctrl.sv
// Multi-source interrupt controller: per-source edge capture into sticky
// pending bits, overflow tracking, level/pulse IRQ and priority-encoded ID.
module irq_ctrl
    import irq_pkg::*;
#(
    parameter int NUM_SRC     = 4,
    parameter int PULSE_LEN   = 3,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    irq_ctrl_if.slave  bus
);

    localparam int ID_W  = id_w(NUM_SRC);
    localparam int CNT_W = pulse_cnt_w(PULSE_LEN);

    logic [NUM_SRC-1:0] src_edge;
    logic [NUM_SRC-1:0] ack_hit;
    logic [NUM_SRC-1:0] enabled_d;
    logic [NUM_SRC-1:0] pending_d, pending_q;
    logic [NUM_SRC-1:0] overflow_d, overflow_q;
    logic               irq_d, irq_q;
    logic               irq_pulse_d, irq_pulse_q;
    logic [ID_W-1:0]    irq_id_d, irq_id_q;
    logic [CNT_W-1:0]   cnt_d, cnt_q;
    src_vec_t           prio_req;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        irq_sync_edge #(
            .SYNC_STAGES (SYNC_STAGES)
        ) u_sync_edge (
            .clk      (clk),
            .rst_n    (rst_n),
            .async_in (bus.src[g]),
            .edge_out (src_edge[g])
        );
    end

    always_comb begin
        ack_hit = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            ack_hit[i] = bus.ack_valid && (bus.ack_id == ID_W'(i));
        end

        // A new edge wins over a same-cycle acknowledge, so no event is lost.
        pending_d  = src_edge | (pending_q & ~ack_hit);
        overflow_d = (overflow_q | (src_edge & pending_q)) & ~ack_hit;

        // Outputs follow the next-state pending so they move on the same edge.
        enabled_d              = pending_d & bus.mask;
        prio_req               = '0;
        prio_req[NUM_SRC-1:0]  = enabled_d;
        irq_d                  = |enabled_d;
        irq_id_d               = ID_W'(lowest_set(prio_req));

        if ((src_edge & bus.mask) != '0) begin
            cnt_d = CNT_W'(PULSE_LEN);
        end else if (cnt_q != '0) begin
            cnt_d = cnt_q - CNT_W'(1);
        end else begin
            cnt_d = '0;
        end
        irq_pulse_d = (cnt_d != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_q   <= '0;
            overflow_q  <= '0;
            irq_q       <= 1'b0;
            irq_id_q    <= '0;
            irq_pulse_q <= 1'b0;
            cnt_q       <= '0;
        end else begin
            pending_q   <= pending_d;
            overflow_q  <= overflow_d;
            irq_q       <= irq_d;
            irq_id_q    <= irq_id_d;
            irq_pulse_q <= irq_pulse_d;
            cnt_q       <= cnt_d;
        end
    end

    assign bus.pending   = pending_q;
    assign bus.overflow  = overflow_q;
    assign bus.irq       = irq_q;
    assign bus.irq_valid = irq_q;
    assign bus.irq_id    = irq_id_q;
    assign bus.irq_pulse = irq_pulse_q;

endmodule

// File: tb/tb_irq_ctrl.sv
// Scoreboard bench for irq_ctrl: default build plus NUM_SRC=5 and
// NUM_SRC=1/PULSE_LEN=1 builds sharing one clock and reset.
module tb_irq_ctrl;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    irq_ctrl_if #(.NUM_SRC(4)) bus4 ();
    irq_ctrl_if #(.NUM_SRC(5)) bus5 ();
    irq_ctrl_if #(.NUM_SRC(1)) bus1 ();

    irq_ctrl #(.NUM_SRC(4), .PULSE_LEN(3), .SYNC_STAGES(2)) u_dut4 (
        .clk (clk), .rst_n (rst_n), .bus (bus4)
    );
    irq_ctrl #(.NUM_SRC(5), .PULSE_LEN(3), .SYNC_STAGES(2)) u_dut5 (
        .clk (clk), .rst_n (rst_n), .bus (bus5)
    );
    irq_ctrl #(.NUM_SRC(1), .PULSE_LEN(1), .SYNC_STAGES(2)) u_dut1 (
        .clk (clk), .rst_n (rst_n), .bus (bus1)
    );

    typedef enum int {P4, O4, I4, U4, D4, V4, P5, O5, I5, D5, P1, I1, U1, V1} sel_e;

    typedef struct {
        string       tag;
        sel_e        sel;
        logic [31:0] exp;
    } sb_item_t;

    sb_item_t sb_q[$];
    int       n_cmp = 0;
    int       n_err = 0;

    function automatic logic [31:0] observe(input sel_e s);
        case (s)
            P4: return 32'(bus4.pending);
            O4: return 32'(bus4.overflow);
            I4: return 32'(bus4.irq);
            U4: return 32'(bus4.irq_pulse);
            D4: return 32'(bus4.irq_id);
            V4: return 32'(bus4.irq_valid);
            P5: return 32'(bus5.pending);
            O5: return 32'(bus5.overflow);
            I5: return 32'(bus5.irq);
            D5: return 32'(bus5.irq_id);
            P1: return 32'(bus1.pending);
            I1: return 32'(bus1.irq);
            U1: return 32'(bus1.irq_pulse);
            V1: return 32'(bus1.irq_valid);
            default: return 32'hdead_beef;
        endcase
    endfunction

    task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_sig(input string tag, input sel_e s, input logic [31:0] exp);
        sb_q.push_back('{tag, s, exp});
    endtask

    task automatic sb_check();
        sb_item_t it;
        while (sb_q.size() > 0) begin
            it = sb_q.pop_front();
            chk_eq(it.tag, observe(it.sel), it.exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic count_pulse4(input int n, output int c);
        c = 0;
        repeat (n) begin
            tick();
            c += int'(bus4.irq_pulse);
        end
    endtask

    task automatic ack4(input int id);
        bus4.ack_valid = 1'b1;
        bus4.ack_id    = 2'(id);
        tick();
        bus4.ack_valid = 1'b0;
    endtask

    task automatic ack5(input int id);
        bus5.ack_valid = 1'b1;
        bus5.ack_id    = 3'(id);
        tick();
        bus5.ack_valid = 1'b0;
    endtask

    task automatic ack1();
        bus1.ack_valid = 1'b1;
        bus1.ack_id    = 1'b0;
        tick();
        bus1.ack_valid = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish, want finish before time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int pc;
        int c;
        bus4.src = '0; bus4.mask = '1; bus4.ack_valid = 1'b0; bus4.ack_id = '0;
        bus5.src = '0; bus5.mask = '1; bus5.ack_valid = 1'b0; bus5.ack_id = '0;
        bus1.src = '0; bus1.mask = '1; bus1.ack_valid = 1'b0; bus1.ack_id = '0;

        // Reset held while sources toggle
        repeat (4) begin
            tick();
            bus4.src = ~bus4.src;
            bus1.src = ~bus1.src;
        end
        expect_sig("rst_pend",  P4, 0);
        expect_sig("rst_ovf",   O4, 0);
        expect_sig("rst_irq",   I4, 0);
        expect_sig("rst_pulse", U4, 0);
        expect_sig("rst_id",    D4, 0);
        expect_sig("rst_valid", V4, 0);
        expect_sig("rst_pend1", P1, 0);
        sb_check();
        bus4.src = '0;
        bus1.src = '0;
        rst_n    = 1'b1;
        expect_sig("post_rst_pend",  P4, 0);
        expect_sig("post_rst_irq",   I4, 0);
        expect_sig("post_rst_pulse", U4, 0);
        tick(5);
        sb_check();

        // Single event on source 2
        bus4.src[2] = 1'b1;
        expect_sig("single_lat_pend", P4, 0);
        tick(2);
        sb_check();
        expect_sig("single_pend",  P4, 4'b0100);
        expect_sig("single_irq",   I4, 1);
        expect_sig("single_id",    D4, 2);
        expect_sig("single_valid", V4, 1);
        expect_sig("single_pulse", U4, 1);
        tick();
        sb_check();
        pc = int'(bus4.irq_pulse);
        count_pulse4(6, c);
        chk_eq("single_pulse_len", 32'(pc + c), 3);
        expect_sig("single_ack_pend",  P4, 0);
        expect_sig("single_ack_irq",   I4, 0);
        expect_sig("single_ack_valid", V4, 0);
        ack4(2);
        sb_check();
        bus4.src = '0;
        tick(4);

        // Priority between sources 3 and 1
        bus4.src = 4'b1010;
        expect_sig("prio_pend", P4, 4'b1010);
        expect_sig("prio_id1",  D4, 1);
        expect_sig("prio_v1",   V4, 1);
        tick(3);
        sb_check();
        expect_sig("prio_id3",   D4, 3);
        expect_sig("prio_pend3", P4, 4'b1000);
        ack4(1);
        sb_check();
        expect_sig("prio_none_valid", V4, 0);
        expect_sig("prio_none_irq",   I4, 0);
        expect_sig("prio_none_id",    D4, 0);
        ack4(3);
        sb_check();
        bus4.src = '0;
        tick(4);

        // Masked event: latched but silent, unmask raises level only
        bus4.mask   = 4'b1110;
        bus4.src[0] = 1'b1;
        expect_sig("mask_pend",  P4, 4'b0001);
        expect_sig("mask_irq",   I4, 0);
        expect_sig("mask_pulse", U4, 0);
        expect_sig("mask_valid", V4, 0);
        tick(3);
        sb_check();
        count_pulse4(4, c);
        chk_eq("mask_no_pulse", 32'(c), 0);
        bus4.mask = 4'b1111;
        expect_sig("unmask_irq",   I4, 1);
        expect_sig("unmask_valid", V4, 1);
        expect_sig("unmask_id",    D4, 0);
        expect_sig("unmask_pulse", U4, 0);
        tick();
        sb_check();
        expect_sig("unmask_ack_pend", P4, 0);
        ack4(0);
        sb_check();
        bus4.src = '0;
        tick(4);

        // Collisions: edge with same-cycle ack, then edge while pending
        bus4.src[1] = 1'b1;
        tick(3);
        bus4.src[1] = 1'b0;
        tick(3);
        bus4.src[1] = 1'b1;
        tick(2);
        bus4.ack_valid = 1'b1;
        bus4.ack_id    = 2'd1;
        expect_sig("coll_set_wins", P4, 4'b0010);
        expect_sig("coll_no_ovf",   O4, 0);
        tick();
        bus4.ack_valid = 1'b0;
        sb_check();
        bus4.src[1] = 1'b0;
        tick(3);
        bus4.src[1] = 1'b1;
        expect_sig("ovf_set",  O4, 4'b0010);
        expect_sig("ovf_pend", P4, 4'b0010);
        tick(3);
        sb_check();
        expect_sig("ovf_ack_ovf",  O4, 0);
        expect_sig("ovf_ack_pend", P4, 0);
        ack4(1);
        sb_check();
        bus4.src = '0;
        tick(5);

        // Retrigger: second enabled event two cycles later extends pulse
        bus4.src[0] = 1'b1;
        tick(2);
        bus4.src[3] = 1'b1;
        count_pulse4(12, c);
        chk_eq("retrig_pulse_len", 32'(c), 5);
        expect_sig("retrig_pend", P4, 4'b1001);
        expect_sig("retrig_id",   D4, 0);
        sb_check();
        ack4(0);
        expect_sig("retrig_ack_valid", V4, 0);
        ack4(3);
        sb_check();
        bus4.src = '0;
        tick(4);

        // NUM_SRC=5 build: out-of-range and non-pending acks
        bus5.src[2] = 1'b1;
        expect_sig("n5_pend", P5, 5'b00100);
        expect_sig("n5_irq",  I5, 1);
        expect_sig("n5_id",   D5, 2);
        tick(3);
        sb_check();
        expect_sig("n5_ack6_pend", P5, 5'b00100);
        expect_sig("n5_ack6_id",   D5, 2);
        expect_sig("n5_ack6_ovf",  O5, 0);
        ack5(6);
        sb_check();
        expect_sig("n5_ack0_pend", P5, 5'b00100);
        ack5(0);
        sb_check();
        bus5.src[4] = 1'b1;
        expect_sig("n5_two_pend", P5, 5'b10100);
        expect_sig("n5_two_id",   D5, 2);
        tick(3);
        sb_check();
        expect_sig("n5_ack2_id",   D5, 4);
        expect_sig("n5_ack2_pend", P5, 5'b10000);
        ack5(2);
        sb_check();
        expect_sig("n5_ack4_pend", P5, 0);
        expect_sig("n5_ack4_irq",  I5, 0);
        ack5(4);
        sb_check();

        // NUM_SRC=1, PULSE_LEN=1 build
        bus1.src = 1'b1;
        expect_sig("n1_lat_pend", P1, 0);
        tick(2);
        sb_check();
        expect_sig("n1_pend",  P1, 1);
        expect_sig("n1_irq",   I1, 1);
        expect_sig("n1_valid", V1, 1);
        expect_sig("n1_pulse", U1, 1);
        tick();
        sb_check();
        expect_sig("n1_pulse_end", U1, 0);
        expect_sig("n1_pend_hold", P1, 1);
        tick();
        sb_check();
        expect_sig("n1_ack_pend", P1, 0);
        expect_sig("n1_ack_irq",  I1, 0);
        ack1();
        sb_check();

        // Reset mid-pulse, source held high across release
        bus4.src[2] = 1'b1;
        expect_sig("mid_pulse_on", U4, 1);
        expect_sig("mid_pend",     P4, 4'b0100);
        tick(4);
        sb_check();
        rst_n = 1'b0;
        expect_sig("arst_pulse", U4, 0);
        expect_sig("arst_pend",  P4, 0);
        expect_sig("arst_irq",   I4, 0);
        expect_sig("arst_valid", V4, 0);
        expect_sig("arst_id",    D4, 0);
        #2;
        sb_check();
        tick(2);
        rst_n = 1'b1;
        expect_sig("rel_lat_pend",  P4, 0);
        expect_sig("rel_lat_pend1", P1, 0);
        tick(2);
        sb_check();
        expect_sig("rel_pend",   P4, 4'b0100);
        expect_sig("rel_pulse",  U4, 1);
        expect_sig("rel_id",     D4, 2);
        expect_sig("rel_pend1",  P1, 1);
        expect_sig("rel_pulse1", U1, 1);
        tick();
        sb_check();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
